// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix reader/writer slice: word width, sweep states
// and the index-width helper.
package matrix_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    s_idle,
    s_fetch,
    s_capture,
    s_present,
    s_done
  } state_t;

  function automatic int unsigned IDX_W(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Two-level (i,j) sweep counter; COL_MAJOR picks which index is innermost.
// The outer index saturates at n-1 so the final advance leaves it in range.
module matrix_index_counter
  import matrix_pkg::*;
#(
  parameter int unsigned n         = 8,
  parameter bit          COL_MAJOR = 1'b0,
  localparam int unsigned W        = IDX_W(n)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         adv,
  output logic [W-1:0] i,
  output logic [W-1:0] j,
  output logic         last
);

  localparam logic [W-1:0] MAX = W'(n - 1);

  logic [W-1:0] inner;
  logic [W-1:0] outer;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      inner <= '0;
      outer <= '0;
    end else if (adv) begin
      if (inner == MAX) begin
        inner <= '0;
        if (outer != MAX) outer <= outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

  assign i    = COL_MAJOR ? inner : outer;
  assign j    = COL_MAJOR ? outer : inner;
  assign last = (inner == MAX) && (outer == MAX);

endmodule

// File: rtl/matrix_reader.sv
// Streams an n x n matrix of words from a synchronous-read RAM over a
// value/value_stb/value_ack handshake, row- or column-major.
module matrix_reader
  import matrix_pkg::*;
#(
  parameter int unsigned n         = 8,
  parameter bit          COL_MAJOR = 1'b0,
  parameter int unsigned ADDR_W    = $clog2(n * n)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [WORD_W-1:0]   mem_rdata,
  output logic [WORD_W-1:0]   value,
  output logic                value_stb,
  input  logic                value_ack,
  output logic [IDX_W(n)-1:0] i,
  output logic [IDX_W(n)-1:0] j,
  output logic                busy,
  output logic                done
);

  state_t              state;
  state_t              state_n;
  logic [WORD_W-1:0]   value_n;
  logic                stb_n;
  logic                done_n;
  logic                clr;
  logic                adv;
  logic                last;
  logic                xfer;

  matrix_index_counter #(
    .n        (n),
    .COL_MAJOR(COL_MAJOR)
  ) u_idx (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .adv (adv),
    .i   (i),
    .j   (j),
    .last(last)
  );

  // Address is always row-major storage order regardless of sweep order.
  assign mem_addr = ADDR_W'(i) * ADDR_W'(n) + ADDR_W'(j);
  assign xfer     = value_stb & value_ack;
  assign busy     = (state != s_idle);

  always_comb begin
    state_n = state;
    value_n = value;
    stb_n   = value_stb;
    done_n  = 1'b0;
    clr     = 1'b0;
    adv     = 1'b0;
    case (state)
      s_idle: begin
        if (start) begin
          clr     = 1'b1;
          state_n = s_fetch;
        end
      end
      s_fetch: state_n = s_capture;
      s_capture: begin
        value_n = mem_rdata;
        stb_n   = 1'b1;
        state_n = s_present;
      end
      s_present: begin
        if (xfer) begin
          stb_n = 1'b0;
          adv   = 1'b1;
          if (last) begin
            done_n  = 1'b1;
            state_n = s_done;
          end else begin
            state_n = s_fetch;
          end
        end
      end
      s_done: begin
        clr     = 1'b1;
        state_n = s_idle;
      end
      default: state_n = s_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= s_idle;
      value     <= '0;
      value_stb <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      value     <= value_n;
      value_stb <= stb_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_matrix_reader.sv
// Self-checking bench: a row-major and a column-major reader share stimulus and
// are compared against an index-arithmetic model of the expected element order.
module tb_matrix_reader;

  localparam int N  = 4;
  localparam int NN = N * N;

  typedef struct {
    logic [31:0] v;
    int          i;
    int          j;
    int          c;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ack;
  logic [3:0]  addr  [2];
  logic [31:0] rdata [2];
  logic [31:0] value [2];
  logic        stb   [2];
  logic        busy  [2];
  logic        done  [2];
  logic [1:0]  ii    [2];
  logic [1:0]  jj    [2];
  logic [31:0] ram   [NN];

  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  xfer_t q [2][$];
  int    done_cnt [2];
  int    done_cyc [2];
  xfer_t mon_x;

  always #5 clk = ~clk;

  matrix_reader #(.n(N), .COL_MAJOR(1'b0)) dut_r (
    .clk(clk), .rst(rst), .start(start), .mem_addr(addr[0]), .mem_rdata(rdata[0]),
    .value(value[0]), .value_stb(stb[0]), .value_ack(ack), .i(ii[0]), .j(jj[0]),
    .busy(busy[0]), .done(done[0]));

  matrix_reader #(.n(N), .COL_MAJOR(1'b1)) dut_c (
    .clk(clk), .rst(rst), .start(start), .mem_addr(addr[1]), .mem_rdata(rdata[1]),
    .value(value[1]), .value_stb(stb[1]), .value_ack(ack), .i(ii[1]), .j(jj[1]),
    .busy(busy[1]), .done(done[1]));

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rdata[0] <= ram[addr[0]];
    rdata[1] <= ram[addr[1]];
  end

  // Record every handshake that the coming edge will complete.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (stb[d] === 1'b1 && ack === 1'b1 && rst === 1'b0) begin
        mon_x.v = value[d];
        mon_x.i = int'(ii[d]);
        mon_x.j = int'(jj[d]);
        mon_x.c = cyc;
        q[d].push_back(mon_x);
      end
      if (done[d] === 1'b1) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
    end
  end

  function automatic xfer_t model(input int d, input int t);
    xfer_t e;
    e.i = (d == 1) ? t % N : t / N;
    e.j = (d == 1) ? t / N : t % N;
    e.v = ram[e.i * N + e.j];
    e.c = 0;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      done_cnt[d] = 0;
      done_cyc[d] = 0;
    end
  endtask

  task automatic fill_ram(input bit rnd);
    for (int t = 0; t < NN; t++) ram[t] = rnd ? $urandom : 32'(t);
  endtask

  task automatic pulse_start(output int sc);
    start = 1'b1;
    sc    = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      step();
      if (done[0] === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({value[d], stb[d], done[d], busy[d], ii[d], jj[d]} !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got value=%h stb=%b done=%b busy=%b i=%0d j=%0d want all zero",
                 d, value[d], stb[d], done[d], busy[d], ii[d], jj[d]);
      end
    end
    step();
  endtask

  task automatic test_row_col();
    int sc; bit ok; xfer_t e;
    fill_ram(1'b0); ack = 1'b1; clear_mon();
    pulse_start(sc);
    wait_done(200, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL row_col_done_timeout: got no done want done within 200 cycles"); end
    repeat (5) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (q[d].size() != NN) begin errors++; $display("FAIL row_col_count dut%0d: got %0d want %0d", d, q[d].size(), NN); end
      for (int t = 0; t < q[d].size() && t < NN; t++) begin
        e = model(d, t);
        checks++;
        if (q[d][t].v !== e.v || q[d][t].i != e.i || q[d][t].j != e.j) begin
          errors++;
          $display("FAIL row_col_elem dut%0d t=%0d: got v=%h i=%0d j=%0d want v=%h i=%0d j=%0d",
                   d, t, q[d][t].v, q[d][t].i, q[d][t].j, e.v, e.i, e.j);
        end
        if (t > 0) begin
          checks++;
          if (q[d][t].c - q[d][t-1].c != 3) begin
            errors++;
            $display("FAIL row_col_rate dut%0d t=%0d: got gap %0d want 3", d, t, q[d][t].c - q[d][t-1].c);
          end
        end
      end
      if (q[d].size() > 0) begin
        checks++;
        if (q[d][0].c - sc != 3) begin errors++; $display("FAIL first_latency dut%0d: got %0d want 3", d, q[d][0].c - sc); end
        checks++;
        if (q[d][$].c - sc != 3 * NN) begin errors++; $display("FAIL sweep_length dut%0d: got %0d want %0d", d, q[d][$].c - sc, 3 * NN); end
        checks++;
        if (done_cyc[d] - q[d][$].c != 1) begin errors++; $display("FAIL done_delay dut%0d: got %0d want 1", d, done_cyc[d] - q[d][$].c); end
      end
      checks++;
      if (done_cnt[d] != 1) begin errors++; $display("FAIL row_col_done_count dut%0d: got %0d want 1", d, done_cnt[d]); end
    end
  endtask

  task automatic test_backpressure();
    int sc; bit ok; xfer_t e;
    fill_ram(1'b1); ack = 1'b1; clear_mon();
    pulse_start(sc);
    for (int k = 0; k < 200 && q[0].size() < 6; k++) step();
    ack = 1'b0;
    for (int k = 0; k < 10 && stb[0] !== 1'b1; k++) step();
    checks++;
    if (stb[0] !== 1'b1) begin errors++; $display("FAIL stall_reach: got stb=%b want 1", stb[0]); end
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        e = model(d, 6);
        checks++;
        if (stb[d] !== 1'b1 || value[d] !== e.v || int'(ii[d]) != e.i || int'(jj[d]) != e.j) begin
          errors++;
          $display("FAIL stall_hold dut%0d: got stb=%b v=%h i=%0d j=%0d want stb=1 v=%h i=%0d j=%0d",
                   d, stb[d], value[d], ii[d], jj[d], e.v, e.i, e.j);
        end
      end
      step();
    end
    ack = 1'b1;
    wait_done(200, ok);
    step();
    checks++;
    if (!ok) begin errors++; $display("FAIL stall_done_timeout: got no done want done"); end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (q[d].size() != NN || done_cnt[d] != 1) begin
        errors++;
        $display("FAIL stall_count dut%0d: got %0d xfers %0d done want %0d xfers 1 done", d, q[d].size(), done_cnt[d], NN);
      end
      for (int t = 0; t < q[d].size() && t < NN; t++) begin
        e = model(d, t);
        checks++;
        if (q[d][t].v !== e.v || q[d][t].i != e.i || q[d][t].j != e.j) begin
          errors++;
          $display("FAIL stall_elem dut%0d t=%0d: got v=%h i=%0d j=%0d want v=%h i=%0d j=%0d",
                   d, t, q[d][t].v, q[d][t].i, q[d][t].j, e.v, e.i, e.j);
        end
      end
    end
  endtask

  task automatic test_restart_ignored();
    int sc; bit ok; bit pulsed; xfer_t e;
    fill_ram(1'b1); clear_mon(); ack = 1'b1;
    pulse_start(sc);
    ok = 1'b0; pulsed = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      ack   = 1'($urandom_range(0, 1));
      start = (!pulsed && q[0].size() == 3);
      if (start) pulsed = 1'b1;
      step();
      if (done[0] === 1'b1) ok = 1'b1;
    end
    start = 1'b0; ack = 1'b1;
    repeat (10) step();
    checks++;
    if (!ok || !pulsed) begin errors++; $display("FAIL restart_timeout: got done=%b pulsed=%b want 1 1", ok, pulsed); end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (q[d].size() != NN || done_cnt[d] != 1 || busy[d] !== 1'b0) begin
        errors++;
        $display("FAIL restart_count dut%0d: got %0d xfers %0d done busy=%b want %0d xfers 1 done busy=0",
                 d, q[d].size(), done_cnt[d], busy[d], NN);
      end
      for (int t = 0; t < q[d].size() && t < NN; t++) begin
        e = model(d, t);
        checks++;
        if (q[d][t].v !== e.v || q[d][t].i != e.i || q[d][t].j != e.j) begin
          errors++;
          $display("FAIL restart_elem dut%0d t=%0d: got v=%h i=%0d j=%0d want v=%h i=%0d j=%0d",
                   d, t, q[d][t].v, q[d][t].i, q[d][t].j, e.v, e.i, e.j);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int sc; bit ok; xfer_t e;
    fill_ram(1'b0); ack = 1'b1; clear_mon();
    pulse_start(sc);
    for (int k = 0; k < 300 && !(q[0].size() == 9 && stb[0] === 1'b1); k++) step();
    checks++;
    if (!(q[0].size() == 9 && stb[0] === 1'b1)) begin
      errors++; $display("FAIL midreset_reach: got %0d xfers stb=%b want 9 xfers stb=1", q[0].size(), stb[0]);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({value[d], stb[d], done[d], busy[d], ii[d], jj[d]} !== '0) begin
        errors++;
        $display("FAIL midreset_state dut%0d: got value=%h stb=%b done=%b busy=%b i=%0d j=%0d want all zero",
                 d, value[d], stb[d], done[d], busy[d], ii[d], jj[d]);
      end
    end
    repeat (6) step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (q[d].size() != 9 || done_cnt[d] != 0) begin
        errors++;
        $display("FAIL midreset_abandon dut%0d: got %0d xfers %0d done want 9 xfers 0 done", d, q[d].size(), done_cnt[d]);
      end
    end
    clear_mon();
    pulse_start(sc);
    wait_done(200, ok);
    step();
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_rerun_timeout: got no done want done"); end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (q[d].size() != NN || done_cnt[d] != 1) begin
        errors++;
        $display("FAIL midreset_rerun_count dut%0d: got %0d xfers %0d done want %0d 1", d, q[d].size(), done_cnt[d], NN);
      end
      for (int t = 0; t < q[d].size() && t < NN; t++) begin
        e = model(d, t);
        checks++;
        if (q[d][t].v !== e.v || q[d][t].i != e.i || q[d][t].j != e.j) begin
          errors++;
          $display("FAIL midreset_rerun_elem dut%0d t=%0d: got v=%h i=%0d j=%0d want v=%h i=%0d j=%0d",
                   d, t, q[d][t].v, q[d][t].i, q[d][t].j, e.v, e.i, e.j);
        end
      end
    end
  endtask

  task automatic test_idle_ack_done();
    int sc; bit ok; xfer_t e;
    fill_ram(1'b1); ack = 1'b1; clear_mon();
    pulse_start(sc);
    wait_done(200, ok);
    start = 1'b1;
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_done_timeout: got no done want done"); end
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b0 || done[d] !== 1'b0 || q[d].size() != NN || done_cnt[d] != 1) begin
        errors++;
        $display("FAIL start_during_done dut%0d: got busy=%b done=%b xfers=%0d dones=%0d want 0 0 %0d 1",
                 d, busy[d], done[d], q[d].size(), done_cnt[d], NN);
      end
    end
    clear_mon();
    sc = cyc;
    step();
    start = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy[d] !== 1'b1) begin errors++; $display("FAIL start_after_done dut%0d: got busy=%b want 1", d, busy[d]); end
    end
    wait_done(200, ok);
    step();
    checks++;
    if (!ok) begin errors++; $display("FAIL idle_rerun_timeout: got no done want done"); end
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (q[d].size() != NN || done_cnt[d] != 1) begin
        errors++;
        $display("FAIL idle_rerun_count dut%0d: got %0d xfers %0d done want %0d 1", d, q[d].size(), done_cnt[d], NN);
      end
      if (q[d].size() > 0) begin
        checks++;
        if (q[d][0].c - sc != 3) begin errors++; $display("FAIL idle_rerun_latency dut%0d: got %0d want 3", d, q[d][0].c - sc); end
      end
      for (int t = 0; t < q[d].size() && t < NN; t++) begin
        e = model(d, t);
        checks++;
        if (q[d][t].v !== e.v || q[d][t].i != e.i || q[d][t].j != e.j) begin
          errors++;
          $display("FAIL idle_rerun_elem dut%0d t=%0d: got v=%h i=%0d j=%0d want v=%h i=%0d j=%0d",
                   d, t, q[d][t].v, q[d][t].i, q[d][t].j, e.v, e.i, e.j);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_row_col();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_idle_ack_done();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_reader.md
Name: matrix_reader

Overview:
- Streams an n x n matrix of 32-bit words out of a synchronous-read memory, one element per handshake.
- Element order is row-major by default, column-major when COL_MAJOR=1.
- Feeds the multiplier datapath from the operand RAMs. It is the producer counterpart of the result writer: it drives value/value_stb and consumes value_ack.
- Sweeps indices i (row) and j (column) and pulses done after the last element is accepted.

Parameters:
- n, 8, matrix dimension; legal range 2..256.
- COL_MAJOR, 0, 0 = j innermost (row-major order); 1 = i innermost (column-major order).
- ADDR_W, $clog2(n*n), memory address width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in s_idle.
- mem_addr  output  ADDR_W  read address, combinational from i,j: i*n+j (always, independent of COL_MAJOR).
- mem_rdata  input  32  memory data, valid the cycle after mem_addr is presented.
- value  output  32  current element; held stable while value_stb=1.
- value_stb  output  1  element valid.
- value_ack  input  1  consumer accepts; transfer = value_stb & value_ack at a rising edge.
- i  output  $clog2(n)  row index of the element being fetched or presented.
- j  output  $clog2(n)  column index of the element being fetched or presented.
- busy  output  1  high in every state except s_idle.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (synchronous, active-high; takes effect at any state, including mid-sweep):
  - state=s_idle; value_stb=0; done=0; value=0; i=0; j=0; busy=0.
  - A partially streamed sweep is abandoned; no done pulse is generated.
- States: s_idle, s_fetch, s_capture, s_present, s_done.
- s_idle:
  - If start=1: i<=0, j<=0, go to s_fetch.
  - Otherwise hold.
  - value_ack is ignored.
- s_fetch: mem_addr valid for exactly one cycle; go to s_capture.
- s_capture: value<=mem_rdata, value_stb<=1, go to s_present.
- s_present:
  - value_stb held high and value held stable until value_ack=1.
  - On transfer: value_stb<=0, then advance the indices:
    - COL_MAJOR=0: if j==n-1 then j<=0 and (i==n-1 ? go to s_done : i<=i+1); else j<=j+1.
    - COL_MAJOR=1: same rule with the roles of i and j swapped.
  - If not finished, go to s_fetch.
- s_done: done<=1 for one cycle; i, j return to 0; go to s_idle.
- Latency and throughput:
  - start sampled at edge E0 -> value_stb visible in the cycle after E2, i.e. 3 cycles.
  - With value_ack tied high: one transfer every 3 cycles.
  - Total for a sweep: 3*n*n cycles from start to the last transfer; done is high in the cycle after the last transfer edge.
- value_ack while value_stb=0 has no effect.
- start while busy=1 is ignored and does not restart the sweep.
- start high in the same cycle done is high is ignored; a new sweep may be started from the next cycle.
- Index wrap: indices never exceed n-1; mem_addr stays in the range 0..n*n-1.
- mem_addr is driven in every state; the memory may ignore it outside s_fetch.

Decomposition:
- Shared package matrix_pkg:
  - WORD_W=32.
  - State localparams (s_idle..s_done), also reused by the writer.
  - IDX_W(n) helper wrapping $clog2.
- One natural sub-module, matrix_index_counter:
  - Inputs: clr, adv, COL_MAJOR.
  - Outputs: i, j, last (high when at the final element).
  - Shared with the writer.

Test Plan:
- n=4, COL_MAJOR=0, RAM word k holds k, value_ack tied 1 -> 16 transfers of values 0..15 in order; one transfer every 3 cycles; done pulses exactly once, 1 cycle after the 16th transfer.
- n=4, COL_MAJOR=1, same RAM -> transfers carry 0,4,8,12,1,5,9,13,...,15; (i,j) at each transfer = (0,0),(1,0),(2,0),(3,0),(0,1),...
- Backpressure: value_ack low for 5 cycles on element 6 -> value_stb stays high, value=6 stable for the whole stall, no index advance; the next element is 7.
- start pulsed again at transfer 3 of 16 -> ignored; the sequence continues unchanged; exactly one done pulse.
- rst asserted while in s_present at element 9 -> next cycle value_stb=0, busy=0, i=j=0, no done; a new start then streams from element 0.
- value_ack held 1 while in s_idle, plus start and done in the same cycle -> no spurious transfer and no restart; a start in the following cycle begins a full sweep.
